ccr_unit: RTL and testbench

//  Condition-code register stage directly downstream of the execute-stage ALU.

---
 rtl/ccr_unit.sv | 136 +++++++++++++
 tb/tb_ccr_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ccr_unit.sv
// ccr_unit: condition-code register stage sitting right after the EX-stage ALU.
//   Holds the {C,N,Z} flags (bit2=C, bit1=N, bit0=Z) and updates each flag
//   under its own write enable. Decides branches from the registered flags.
//   A taken conditional jump clears the flag it tested. On interrupt entry
//   the CCR is pushed to a small LIFO shadow stack, and RTI pops it back.
//
// Ports
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   alu_flags     {C,N,Z} from the ALU in the current cycle
//   flag_we       per-flag write enable
//   stall         hold all state; no jump is taken
//   flush         squash the EX instruction (flag write and jump only)
//   jmp_req       branch present; jmp_cond selects 00 JZ, 01 JN, 10 JC, 11 JMP
//   int_save      push CCR onto the shadow stack
//   rti_restore   pop the shadow stack into CCR
//   ccr           registered flags
//   jmp_taken     combinational branch decision
//   shadow_full   stack holds SHADOW_DEPTH entries
//   shadow_empty  stack holds no entries
//   ccr_err       sticky flag for overflow, underflow or save+restore together
module ccr_unit #(
  parameter int FLAG_W       = 3,
  parameter int SHADOW_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLAG_W-1:0] alu_flags,
  input  logic [FLAG_W-1:0] flag_we,
  input  logic              stall,
  input  logic              flush,
  input  logic              jmp_req,
  input  logic [1:0]        jmp_cond,
  input  logic              int_save,
  input  logic              rti_restore,
  output logic [FLAG_W-1:0] ccr,
  output logic              jmp_taken,
  output logic              shadow_full,
  output logic              shadow_empty,
  output logic              ccr_err
);

  localparam int PTR_W = $clog2(SHADOW_DEPTH + 1);

  logic [FLAG_W-1:0] ccr_q, ccr_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [FLAG_W-1:0] stack_q [SHADOW_DEPTH];
  logic [FLAG_W-1:0] stack_d [SHADOW_DEPTH];
  logic              err_q, err_d;

  logic              cond;
  logic              full, empty;
  logic [FLAG_W-1:0] top;
  logic [FLAG_W-1:0] we_eff;

  assign full  = (ptr_q == PTR_W'(SHADOW_DEPTH));
  assign empty = (ptr_q == '0);

  // The branch sees only the registered flags. A flag written in this cycle
  // becomes visible to a branch one cycle later.
  always_comb begin
    cond = 1'b1;
    case (jmp_cond)
      2'b00:   cond = ccr_q[0];
      2'b01:   cond = ccr_q[1];
      2'b10:   cond = ccr_q[2];
      default: cond = 1'b1;
    endcase
    jmp_taken = jmp_req & ~stall & ~flush & cond;
  end

  // Top-of-stack read. A compare loop keeps the index within the array bounds.
  always_comb begin
    top = '0;
    for (int i = 0; i < SHADOW_DEPTH; i++) begin
      if (ptr_q == PTR_W'(i + 1)) top = stack_q[i];
    end
  end

  assign we_eff = flush ? '0 : flag_we;

  always_comb begin
    ccr_d   = ccr_q;
    ptr_d   = ptr_q;
    err_d   = err_q;
    stack_d = stack_q;
    if (!stall) begin
      if (int_save && rti_restore) begin
        err_d = 1'b1;
      end else if (rti_restore) begin
        // A pop overrides any flag write or jump clear in the same cycle.
        if (empty) begin
          ccr_d = '0;
          err_d = 1'b1;
        end else begin
          ccr_d = top;
          ptr_d = ptr_q - PTR_W'(1);
        end
      end else begin
        ccr_d = (ccr_q & ~we_eff) | (alu_flags & we_eff);
        // jmp_cond 00/01/10 matches flag bit 0/1/2. The clear wins over a write.
        if (jmp_taken && jmp_cond != 2'b11) ccr_d[jmp_cond] = 1'b0;
        // The push stores the pre-update CCR while the flag update still proceeds.
        if (int_save) begin
          if (full) begin
            err_d = 1'b1;
          end else begin
            for (int i = 0; i < SHADOW_DEPTH; i++) begin
              if (ptr_q == PTR_W'(i)) stack_d[i] = ccr_q;
            end
            ptr_d = ptr_q + PTR_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ccr_q <= '0;
      ptr_q <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < SHADOW_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      ccr_q <= ccr_d;
      ptr_q <= ptr_d;
      err_q <= err_d;
      for (int i = 0; i < SHADOW_DEPTH; i++) stack_q[i] <= stack_d[i];
    end
  end

  assign ccr          = ccr_q;
  assign shadow_full  = full;
  assign shadow_empty = empty;
  assign ccr_err      = err_q;

endmodule

// File: tb/tb_ccr_unit.sv
module tb_ccr_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] alu_flags, flag_we;
  logic       stall, flush, jmp_req, int_save, rti_restore;
  logic [1:0] jmp_cond;
  logic [2:0] ccr;
  logic       jmp_taken, shadow_full, shadow_empty, ccr_err;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [2:0] m_ccr;
  logic [2:0] m_stack[$];
  logic       m_err;

  ccr_unit #(.FLAG_W(3), .SHADOW_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .alu_flags(alu_flags), .flag_we(flag_we),
    .stall(stall), .flush(flush), .jmp_req(jmp_req), .jmp_cond(jmp_cond),
    .int_save(int_save), .rti_restore(rti_restore), .ccr(ccr),
    .jmp_taken(jmp_taken), .shadow_full(shadow_full),
    .shadow_empty(shadow_empty), .ccr_err(ccr_err)
  );

  always #5 clk = ~clk;

  function automatic logic exp_taken();
    logic c;
    c = (jmp_cond == 2'd3) ? 1'b1 : m_ccr[jmp_cond];
    return jmp_req && !stall && !flush && c;
  endfunction

  task automatic model_reset();
    m_ccr = 3'b000;
    m_stack.delete();
    m_err = 1'b0;
  endtask

  task automatic model_update();
    logic       tk;
    logic [2:0] nc;
    tk = exp_taken();
    if (stall) return;
    if (int_save && rti_restore) begin
      m_err = 1'b1;
    end else if (rti_restore) begin
      if (m_stack.size() == 0) begin
        m_ccr = 3'b000;
        m_err = 1'b1;
      end else begin
        m_ccr = m_stack.pop_back();
      end
    end else begin
      nc = m_ccr;
      for (int b = 0; b < 3; b++) begin
        if (!flush && flag_we[b]) nc[b] = alu_flags[b];
        if (tk && jmp_cond != 2'd3 && jmp_cond == b[1:0]) nc[b] = 1'b0;
      end
      if (int_save) begin
        if (m_stack.size() == 2) m_err = 1'b1;
        else m_stack.push_back(m_ccr);
      end
      m_ccr = nc;
    end
  endtask

  task automatic drive(input logic [2:0] we, input logic [2:0] alu,
                       input logic st, input logic fl, input logic jr,
                       input logic [1:0] jc, input logic sv, input logic rt);
    flag_we = we; alu_flags = alu; stall = st; flush = fl;
    jmp_req = jr; jmp_cond = jc; int_save = sv; rti_restore = rt;
  endtask

  task automatic idle();
    drive(3'b000, 3'b000, 0, 0, 0, 2'd0, 0, 0);
  endtask

  // advance one clock; afterwards we sit 1 time unit past the rising edge
  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    idle();
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    model_reset();
    #2;
    checks++; if (ccr !== 3'b000) begin errors++; $display("FAIL reset_ccr: got %b expected 000", ccr); end
    checks++; if (shadow_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", shadow_empty); end
    checks++; if (shadow_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", shadow_full); end
    checks++; if (ccr_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", ccr_err); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_flag_write();
    do_reset();
    drive(3'b111, 3'b101, 0, 0, 0, 2'd0, 0, 0); tick();
    checks++; if (ccr !== 3'b101) begin errors++; $display("FAIL write_all: got %b expected 101", ccr); end
    drive(3'b010, 3'b010, 0, 0, 0, 2'd0, 0, 0); tick();
    checks++; if (ccr !== 3'b111) begin errors++; $display("FAIL write_n: got %b expected 111", ccr); end
  endtask

  task automatic test_jump();
    do_reset();
    drive(3'b111, 3'b001, 0, 0, 0, 2'd0, 0, 0); tick();
    drive(3'b000, 3'b000, 0, 0, 1, 2'd0, 0, 0); #1;
    checks++; if (jmp_taken !== 1'b1) begin errors++; $display("FAIL jz_taken: got %b expected 1", jmp_taken); end
    tick();
    checks++; if (ccr !== 3'b000) begin errors++; $display("FAIL jz_clear: got %b expected 000", ccr); end
    drive(3'b111, 3'b001, 0, 0, 0, 2'd0, 0, 0); tick();
    drive(3'b000, 3'b000, 0, 0, 1, 2'd3, 0, 0); #1;
    checks++; if (jmp_taken !== 1'b1) begin errors++; $display("FAIL jmp_taken: got %b expected 1", jmp_taken); end
    tick();
    checks++; if (ccr !== 3'b001) begin errors++; $display("FAIL jmp_hold: got %b expected 001", ccr); end
    drive(3'b000, 3'b000, 0, 0, 1, 2'd1, 0, 0); #1;
    checks++; if (jmp_taken !== 1'b0) begin errors++; $display("FAIL jn_not_taken: got %b expected 0", jmp_taken); end
    tick();
    // clear wins over a same-cycle write of the tested flag
    drive(3'b001, 3'b001, 0, 0, 1, 2'd0, 0, 0); tick();
    checks++; if (ccr !== 3'b000) begin errors++; $display("FAIL clear_wins: got %b expected 000", ccr); end
    // no bypass: writing Z now does not make this JZ taken
    drive(3'b001, 3'b001, 0, 0, 1, 2'd0, 0, 0); #1;
    checks++; if (jmp_taken !== 1'b0) begin errors++; $display("FAIL no_bypass: got %b expected 0", jmp_taken); end
    tick();
    checks++; if (ccr !== 3'b001) begin errors++; $display("FAIL late_write: got %b expected 001", ccr); end
  endtask

  task automatic test_save_restore();
    do_reset();
    drive(3'b111, 3'b100, 0, 0, 0, 2'd0, 0, 0); tick();
    drive(3'b111, 3'b011, 0, 0, 0, 2'd0, 1, 0); tick();
    checks++; if (ccr !== 3'b011) begin errors++; $display("FAIL save_ccr: got %b expected 011", ccr); end
    checks++; if (shadow_empty !== 1'b0) begin errors++; $display("FAIL save_nonempty: got %b expected 0", shadow_empty); end
    drive(3'b111, 3'b111, 0, 0, 0, 2'd0, 0, 1); tick();
    checks++; if (ccr !== 3'b100) begin errors++; $display("FAIL restore_ccr: got %b expected 100", ccr); end
    checks++; if (shadow_empty !== 1'b1) begin errors++; $display("FAIL restore_empty: got %b expected 1", shadow_empty); end
    // save together with restore is illegal and changes nothing but the error flag
    drive(3'b111, 3'b010, 0, 0, 0, 2'd0, 1, 1); tick();
    checks++; if (ccr !== 3'b100 || ccr_err !== 1'b1 || shadow_empty !== 1'b1) begin
      errors++; $display("FAIL illegal_both: got ccr=%b err=%b empty=%b expected 100 1 1", ccr, ccr_err, shadow_empty);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    drive(3'b111, 3'b100, 0, 0, 0, 2'd0, 0, 0); tick();
    drive(3'b111, 3'b010, 0, 0, 0, 2'd0, 1, 0); tick();
    checks++; if (shadow_full !== 1'b0) begin errors++; $display("FAIL full_after1: got %b expected 0", shadow_full); end
    drive(3'b111, 3'b001, 0, 0, 0, 2'd0, 1, 0); tick();
    checks++; if (shadow_full !== 1'b1 || ccr_err !== 1'b0) begin
      errors++; $display("FAIL full_after2: got full=%b err=%b expected 1 0", shadow_full, ccr_err);
    end
    drive(3'b111, 3'b111, 0, 0, 0, 2'd0, 1, 0); tick();
    checks++; if (ccr_err !== 1'b1 || ccr !== 3'b111) begin
      errors++; $display("FAIL overflow: got err=%b ccr=%b expected 1 111", ccr_err, ccr);
    end
    drive(3'b000, 3'b000, 0, 0, 0, 2'd0, 0, 1); tick();
    checks++; if (ccr !== 3'b010) begin errors++; $display("FAIL pop1: got %b expected 010", ccr); end
    drive(3'b000, 3'b000, 0, 0, 0, 2'd0, 0, 1); tick();
    checks++; if (ccr !== 3'b100) begin errors++; $display("FAIL pop2: got %b expected 100", ccr); end
    drive(3'b111, 3'b111, 0, 0, 0, 2'd0, 0, 1); tick();
    checks++; if (ccr !== 3'b000 || shadow_empty !== 1'b1 || ccr_err !== 1'b1) begin
      errors++; $display("FAIL underflow: got ccr=%b empty=%b err=%b expected 000 1 1", ccr, shadow_empty, ccr_err);
    end
  endtask

  task automatic test_stall_flush();
    do_reset();
    drive(3'b111, 3'b001, 0, 0, 0, 2'd0, 0, 0); tick();
    drive(3'b111, 3'b110, 1, 0, 1, 2'd3, 1, 0); #1;
    checks++; if (jmp_taken !== 1'b0) begin errors++; $display("FAIL stall_taken: got %b expected 0", jmp_taken); end
    tick();
    checks++; if (ccr !== 3'b001 || shadow_empty !== 1'b1) begin
      errors++; $display("FAIL stall_hold: got ccr=%b empty=%b expected 001 1", ccr, shadow_empty);
    end
    drive(3'b111, 3'b110, 0, 1, 1, 2'd0, 0, 0); #1;
    checks++; if (jmp_taken !== 1'b0) begin errors++; $display("FAIL flush_taken: got %b expected 0", jmp_taken); end
    tick();
    checks++; if (ccr !== 3'b001) begin errors++; $display("FAIL flush_nowrite: got %b expected 001", ccr); end
    drive(3'b111, 3'b110, 0, 1, 0, 2'd0, 1, 0); tick();
    checks++; if (shadow_empty !== 1'b0 || ccr !== 3'b001) begin
      errors++; $display("FAIL flush_push: got empty=%b ccr=%b expected 0 001", shadow_empty, ccr);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(3'b000, 3'b000, 0, 0, 0, 2'd0, 1, 1); tick();
    drive(3'b111, 3'b110, 0, 0, 0, 2'd0, 0, 0); tick();
    drive(3'b000, 3'b000, 0, 0, 0, 2'd0, 1, 0); tick();
    idle();
    checks++; if (ccr !== 3'b110 || shadow_empty !== 1'b1 - 1'b1 || ccr_err !== 1'b1) begin
      errors++; $display("FAIL pre_reset: got ccr=%b empty=%b err=%b expected 110 0 1", ccr, shadow_empty, ccr_err);
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checks++; if (ccr !== 3'b000 || shadow_empty !== 1'b1 || ccr_err !== 1'b0) begin
      errors++; $display("FAIL async_reset: got ccr=%b empty=%b err=%b expected 000 1 0", ccr, shadow_empty, ccr_err);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic et;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      drive(3'($urandom), 3'($urandom), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 7) == 0), 1'($urandom), 2'($urandom),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0));
      #1;
      et = exp_taken();
      checks++; if (jmp_taken !== et) begin errors++; $display("FAIL rnd_taken[%0d]: got %b expected %b", n, jmp_taken, et); end
      tick();
      checks++; if (ccr !== m_ccr || ccr_err !== m_err ||
                    shadow_empty !== (m_stack.size() == 0) || shadow_full !== (m_stack.size() == 2)) begin
        errors++;
        $display("FAIL rnd_state[%0d]: got ccr=%b err=%b empty=%b full=%b expected ccr=%b err=%b depth=%0d",
                 n, ccr, ccr_err, shadow_empty, shadow_full, m_ccr, m_err, m_stack.size());
      end
      if (n % 100 == 99) do_reset();
    end
  endtask

  initial begin
    rst = 1'b0;
    idle();
    test_reset();
    test_flag_write();
    test_jump();
    test_save_restore();
    test_overflow();
    test_stall_flush();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
